// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on
// stall or branch flush, and a saturating stall-cycle counter.
module id_ex_hazard_reg #(
    parameter int DW = 32,
    parameter int RW = 5,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic          id_regds,
    input  logic          id_branch,
    input  logic          id_mread,
    input  logic          id_mtor,
    input  logic          id_mwrite,
    input  logic          id_alusrc,
    input  logic          id_urw,
    input  logic [2:0]    id_aop,
    input  logic [DW-1:0] id_pc4,
    input  logic [DW-1:0] id_rd1,
    input  logic [DW-1:0] id_rd2,
    input  logic [DW-1:0] id_imm,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic          flush,
    output logic          ex_valid,
    output logic          ex_regds,
    output logic          ex_branch,
    output logic          ex_mread,
    output logic          ex_mtor,
    output logic          ex_mwrite,
    output logic          ex_alusrc,
    output logic          ex_urw,
    output logic [2:0]    ex_aop,
    output logic [DW-1:0] ex_pc4,
    output logic [DW-1:0] ex_rd1,
    output logic [DW-1:0] ex_rd2,
    output logic [DW-1:0] ex_imm,
    output logic [RW-1:0] ex_rs,
    output logic [RW-1:0] ex_rt,
    output logic [RW-1:0] ex_rd,
    output logic          stall,
    output logic [CW-1:0] stall_cnt
);

    localparam int NC = 10;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [NC-1:0] ctrl_in;
    logic [NC-1:0] ctrl_next;
    logic [NC-1:0] ctrl_reg;
    logic          load_ctrl;
    logic          valid_next;
    logic          valid_reg;
    logic          hazard;
    logic [CW-1:0] stall_cnt_reg;

    assign ctrl_in = {id_aop, id_urw, id_mtor, id_mwrite, id_mread,
                      id_branch, id_alusrc, id_regds};

    // Load-use: the load in EX writes rt, which the decode instruction reads.
    assign hazard = valid_reg & ctrl_reg[3] & (ex_rt != '0) & id_valid
                  & ((ex_rt == id_rs) | (ex_rt == id_rt));
    assign stall  = hazard & ~flush;

    // Mux rather than AND so undefined-opcode X controls never reach EX.
    assign load_ctrl  = id_valid & ~flush & ~stall;
    assign valid_next = load_ctrl ? 1'b1 : 1'b0;

    generate
        for (genvar gi = 0; gi < NC; gi++) begin : g_ctrl
            assign ctrl_next[gi] = load_ctrl ? ctrl_in[gi] : 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg     <= 1'b0;
            ctrl_reg      <= '0;
            ex_pc4        <= '0;
            ex_rd1        <= '0;
            ex_rd2        <= '0;
            ex_imm        <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_rd         <= '0;
            stall_cnt_reg <= '0;
        end else begin
            valid_reg <= valid_next;
            ctrl_reg  <= ctrl_next;
            // Data and indices are don't-care in a bubble, so always track ID.
            ex_pc4    <= id_pc4;
            ex_rd1    <= id_rd1;
            ex_rd2    <= id_rd2;
            ex_imm    <= id_imm;
            ex_rs     <= id_rs;
            ex_rt     <= id_rt;
            ex_rd     <= id_rd;
            if (stall && (stall_cnt_reg != CNT_MAX))
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign ex_valid  = valid_reg;
    assign ex_regds  = ctrl_reg[0];
    assign ex_alusrc = ctrl_reg[1];
    assign ex_branch = ctrl_reg[2];
    assign ex_mread  = ctrl_reg[3];
    assign ex_mwrite = ctrl_reg[4];
    assign ex_mtor   = ctrl_reg[5];
    assign ex_urw    = ctrl_reg[6];
    assign ex_aop    = ctrl_reg[9:7];
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: doc/id_ex_hazard_reg.md
Name: id_ex_hazard_reg

Overview:
- ID/EX pipeline register, directly downstream of the decode-stage control unit.
- Captures the control bundle (WB: MtoR, Urw; M: Branch, MRead, MWrite; EX: RegDs, AOp, ALUsrc) and decode-stage operands for the EX stage.
- Contains the load-use hazard detector: it stalls PC and IF/ID, and inserts a bubble.
- Supports a branch-flush bubble and keeps a saturating stall counter for performance debug.

Parameters:
- DW, 32, datapath width of PC+4, register read data and sign-extended immediate.
- RW, 5, register index width.
- CW, 16, stall counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset (one clock; reset is synchronous and active-high).
- id_valid  in  1  decode stage holds a real instruction.
- id_regds, id_branch, id_mread, id_mtor, id_mwrite, id_alusrc, id_urw  in  1 each  control bits from the control unit.
- id_aop  in  3  ALU op class from the control unit.
- id_pc4  in  DW  PC+4 of the decode instruction.
- id_rd1, id_rd2  in  DW  register file read data.
- id_imm  in  DW  sign-extended immediate.
- id_rs, id_rt, id_rd  in  RW  register indices.
- flush  in  1  branch taken in MEM; kill the decode instruction.
- ex_valid  out  1  EX holds a real instruction.
- ex_regds, ex_branch, ex_mread, ex_mtor, ex_mwrite, ex_alusrc, ex_urw  out  1 each  registered control.
- ex_aop  out  3  registered ALU op class.
- ex_pc4, ex_rd1, ex_rd2, ex_imm  out  DW  registered data.
- ex_rs, ex_rt, ex_rd  out  RW  registered indices.
- stall  out  1  combinational; hold PC and IF/ID this cycle.
- stall_cnt  out  CW  number of stall cycles, saturating.

Behaviour:
- Reset (rst=1 at posedge):
  - ex_valid=0.
  - All ex_ control outputs =0; ex_aop=3'b000.
  - ex_ data and index outputs =0.
  - stall_cnt=0.
  - Reset overrides flush and stall.
- Hazard detect (combinational):
  - stall = ex_valid & ex_mread & (ex_rt!=0) & id_valid & ((ex_rt==id_rs) | (ex_rt==id_rt)).
  - stall is forced to 0 when flush=1.
- Per posedge, in priority order:
  1. rst: reset values as above.
  2. flush or stall: load a bubble.
     - Bubble: ex_valid=0, all control bits =0, ex_aop=0.
     - Data and index fields load the current id_ values; they are don't-care but must be known (no X).
  3. Otherwise: load all id_ fields. ex_valid=id_valid.
     - If id_valid=0, control bits load as 0 regardless of inputs.
- X-masking: control inputs may be X for undefined opcodes. When id_valid=0, ex_ control bits must never be X.
- Latency: one cycle from id_ inputs to ex_ outputs.
- Stall duration: a load-use stall lasts exactly one cycle. The bubble clears ex_mread, so stall drops on the next cycle with the same ID instruction still held upstream.
- No double stall from a single load.
- stall_cnt:
  - Increments by 1 on each posedge where stall=1 and rst=0.
  - Saturates at 2^CW-1 and holds there.
  - Not affected by flush.
- Register $0: ex_rt==0 never raises stall, even if ex_mread=1.
- Simultaneous flush and stall condition: flush wins, stall=0, bubble loaded, stall_cnt unchanged.
- Reset mid-stall: next cycle ex_valid=0 and stall=0.

Test Plan:
- Reset then pass-through: rst 2 cycles, then id_valid=1, R-type controls, id_rs=1, id_rt=2, id_rd=3, id_rd1=32'h10, id_rd2=32'h20 -> next cycle ex_valid=1, ex_regds=1, ex_aop=3'b010, ex_urw=1, ex_rd1=32'h10, stall=0.
- Load-use: LW with id_rt=8 latched to EX (ex_mread=1); next ID instruction has id_rs=8 -> stall=1 that cycle; next EX is bubble (ex_valid=0, ex_mwrite=0, ex_urw=0); following cycle stall=0; stall_cnt=1.
- $0 exemption: LW with rt=0 in EX, ID id_rs=0 -> stall=0, instruction passes.
- Flush priority: load-use condition present and flush=1 -> stall=0, EX bubble, stall_cnt unchanged.
- X masking: id_valid=0 with all control inputs X -> ex_ control outputs all 0, ex_valid=0.
- Counter saturation (CW=2): force 5 consecutive stall cycles -> stall_cnt sequence 1,2,3,3,3; rst -> 0.
